// File: rtl/fixed_requant_pkg.sv
// Fixed-point requantisation helpers: tensor depth and
// per-lane round-half-up / saturate on a wide signed value.
package fixed_requant_pkg;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rs_t;

  function automatic int calc_depth(
    input int d0,
    input int p0,
    input int d1,
    input int p1
  );
    return ((d0 + p0 - 1) / p0) * ((d1 + p1 - 1) / p1);
  endfunction

  // 64-bit working width so neither the rounding add nor
  // a left shift can wrap for any practical lane width.
  function automatic rs_t round_sat(
    input logic signed [63:0] x,
    input int                 sh,
    input int                 ow
  );
    rs_t                r;
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (sh > 0)
      t = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    else
      t = x <<< (-sh);
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    r.sat = (t > hi) || (t < lo);
    if (t > hi)
      r.val = hi;
    else if (t < lo)
      r.val = lo;
    else
      r.val = t;
    return r;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// One-lane combinational requantiser.
// din: IN_W-bit signed; dout: OUT_W-bit signed; sat: clipped.
module fixed_round_sat
  import fixed_requant_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int IN_F  = 8,
  parameter int OUT_W = 8,
  parameter int OUT_F = 4
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  localparam int SH = IN_F - OUT_F;

  logic signed [63:0] x;
  rs_t                r;
  logic               unused_hi;

  always_comb begin
    x    = 64'(signed'(din));
    r    = round_sat(x, SH, OUT_W);
    dout = r.val[OUT_W-1:0];
    sat  = r.sat;
  end

  assign unused_hi = ^r.val[63:OUT_W];

endmodule

// File: rtl/fixed_requant_stage.sv
// Requantise stage: P lanes, 1-cycle latency, skid buffer,
// beat counter with last, sticky per-tensor sat_flag.
module fixed_requant_stage
  import fixed_requant_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  localparam int P =
    DATA_IN_0_PARALLELISM_DIM_0 *
    DATA_IN_0_PARALLELISM_DIM_1,
  localparam int IW = DATA_IN_0_PRECISION_0,
  localparam int OW = DATA_OUT_0_PRECISION_0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] data_in_0 [P],
  input  logic          data_in_0_valid,
  output logic          data_in_0_ready,
  output logic [OW-1:0] data_out_0 [P],
  output logic          data_out_0_valid,
  input  logic          data_out_0_ready,
  output logic          data_out_0_last,
  output logic          sat_flag
);

  localparam int DEPTH = calc_depth(
    DATA_IN_0_TENSOR_SIZE_DIM_0,
    DATA_IN_0_PARALLELISM_DIM_0,
    DATA_IN_0_TENSOR_SIZE_DIM_1,
    DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  logic [OW-1:0] rq [P];
  logic [P-1:0]  rq_sat;

  for (genvar g = 0; g < P; g++) begin : g_lane
    fixed_round_sat #(
      .IN_W  (IW),
      .IN_F  (DATA_IN_0_PRECISION_1),
      .OUT_W (OW),
      .OUT_F (DATA_OUT_0_PRECISION_1)
    ) u_rs (
      .din  (data_in_0[g]),
      .dout (rq[g]),
      .sat  (rq_sat[g])
    );
  end

  logic [OW-1:0] main_d [P];
  logic [OW-1:0] skid_d [P];
  logic          main_v;
  logic          skid_v;
  logic          main_s;
  logic          skid_s;
  logic          rdy_q;
  logic          sat_q;
  logic [CW-1:0] cnt;

  logic in_fire;
  logic out_fire;
  logic last_beat;
  logic main_v_n;
  logic skid_v_n;
  logic ld_main;
  logic ld_skid;
  logic from_skid;

  assign in_fire   = data_in_0_valid && rdy_q;
  assign out_fire  = main_v && data_out_0_ready;
  assign last_beat = (cnt == LAST_IDX);

  // rdy_q tracks !skid_v, so a beat is only accepted
  // while the skid slot is free.
  always_comb begin
    main_v_n  = main_v;
    skid_v_n  = skid_v;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    if (skid_v) begin
      if (out_fire) begin
        from_skid = 1'b1;
        skid_v_n  = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_v || out_fire) begin
        ld_main  = 1'b1;
        main_v_n = 1'b1;
      end else begin
        ld_skid  = 1'b1;
        skid_v_n = 1'b1;
      end
    end else if (out_fire) begin
      main_v_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_s <= 1'b0;
      skid_s <= 1'b0;
      rdy_q  <= 1'b0;
      sat_q  <= 1'b0;
      cnt    <= '0;
      for (int i = 0; i < P; i++) begin
        main_d[i] <= '0;
        skid_d[i] <= '0;
      end
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
      if (from_skid) begin
        main_d <= skid_d;
        main_s <= skid_s;
      end else if (ld_main) begin
        main_d <= rq;
        main_s <= |rq_sat;
      end
      if (ld_skid) begin
        skid_d <= rq;
        skid_s <= |rq_sat;
      end
      if (out_fire) begin
        cnt   <= last_beat ? '0 : cnt + CW'(1);
        sat_q <= last_beat ? 1'b0 : (sat_q | main_s);
      end
    end
  end

  // The presented beat's own saturation is folded in so
  // the flag covers the beat that caused it.
  assign data_out_0       = main_d;
  assign data_out_0_valid = main_v;
  assign data_in_0_ready  = rdy_q;
  assign data_out_0_last  = main_v && last_beat;
  assign sat_flag         = sat_q | (main_v & main_s);

endmodule

// File: doc/fixed_requant_stage.md
FIXED_REQUANT_STAGE -- requirements
Module: fixed_requant_stage

Interface
REQ-001 The block SHALL have parameter DATA_IN_0_PRECISION_0, default 16, meaning input total bits (signed two's complement).
REQ-002 The block SHALL have parameter DATA_IN_0_PRECISION_1, default 8, meaning input fraction bits.
REQ-003 The block SHALL have parameters DATA_IN_0_TENSOR_SIZE_DIM_0 / _DIM_1, defaults 10 / 1, meaning tensor shape.
REQ-004 The block SHALL have parameters DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, defaults 1 / 1, meaning lanes per beat.
REQ-005 The block SHALL have parameters DATA_OUT_0_PRECISION_0 / _1, defaults 8 / 4, meaning output total / fraction bits.
REQ-006 The block SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock; reset is synchronous and active-low.
REQ-007 The block SHALL have port data_in_0 (input, unpacked array of P = PAR_DIM_0*PAR_DIM_1 lanes, DATA_IN_0_PRECISION_0 bits each), fed by the activation stage output.
REQ-008 The block SHALL have ports data_in_0_valid (input, 1) and data_in_0_ready (output, 1).
REQ-009 The block SHALL have port data_out_0 (output, P lanes, DATA_OUT_0_PRECISION_0 bits each).
REQ-010 The block SHALL have ports data_out_0_valid (output, 1) and data_out_0_ready (input, 1).
REQ-011 The block SHALL have port data_out_0_last (output, 1), high on the final beat of each tensor.
REQ-012 The block SHALL have port sat_flag (output, 1), a sticky per-tensor saturation indicator.

Function
REQ-013 Per lane: for SH = IN_FRAC - OUT_FRAC > 0, the block SHALL add 2^(SH-1), arithmetic-shift right by SH (round half up); for SH <= 0, it SHALL shift left by -SH.
REQ-014 Intermediate arithmetic SHALL be IN_WIDTH+2 bits, no overflow.
REQ-015 Results SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-016 Transfer SHALL occur on any cycle with valid && ready high, on either side.
REQ-017 Main output register: loads on input transfer when empty or when draining in the same cycle; latency 1 cycle input-to-output valid.
REQ-018 A one-beat skid register SHALL capture an accepted beat when the main register is full and data_out_0_ready is low.
REQ-019 data_in_0_ready SHALL equal the registered inverse of skid-full (no combinational path from data_out_0_ready).
REQ-020 Full throughput SHALL be 1 beat per cycle while data_out_0_ready is held high.
REQ-021 Order SHALL be preserved; with no drops or duplicates under arbitrary ready toggling.
REQ-022 data_out_0 and data_out_0_valid SHALL be stable while valid && !ready.
REQ-023 The beat counter SHALL count output transfers 0..DEPTH-1, DEPTH = ceil(DIM_0/PAR_0)*ceil(DIM_1/PAR_1), wrapping to 0 after the last transfer.
REQ-024 data_out_0_last SHALL be high iff the counter is DEPTH-1 and data_out_0_valid is high; for DEPTH = 1 it SHALL be high on every beat.
REQ-025 sat_flag SHALL set when any lane of a transferred output beat saturated, include that beat, remain until the last beat transfers, then clear the next cycle unless that next transferred beat saturates.
REQ-026 Simultaneous input and output transfers with skid empty SHALL replace the main register with no bubble.
REQ-027 Skid full with an output transfer SHALL move skid to main, ready rising the next cycle.

Reset
REQ-028 While rst is low at a clk edge, outputs SHALL clear: data_out_0_valid = 0, data_in_0_ready = 0, data_out_0_last = 0, sat_flag = 0, data_out_0 = 0, counter = 0, skid empty.
REQ-029 data_in_0_ready SHALL be 1 on the first cycle after rst returns high.
REQ-030 Reset mid-tensor SHALL discard in-flight beats; the next beat accepted SHALL be counted as beat 0.

Structure
REQ-031 The round/saturate function and the depth calculation SHALL live in a shared package, fixed_requant_pkg.
REQ-032 One sub-module, fixed_round_sat (combinational, one lane), SHALL be instantiated P times.

Verification
REQ-033 16/8 -> 8/4, in 0x0118 -> out 0x12; in 0xFFF8 -> 0x00; in 0x0108 -> 0x11.
REQ-034 in 0x0900 -> 0x7F, sat_flag=1; in 0xF700 -> 0x80; sat_flag SHALL clear after the last beat.
REQ-035 DEPTH=10, ready high: 10 back-to-back beats, one per cycle, last on the 10th only; the 11th beat SHALL have counter=0.
REQ-036 ready low 3 cycles during streaming: exactly 2 beats held (main+skid), data_in_0_ready low; no loss or reorder on release.
REQ-037 rst low after beat 4 of 10, then 10 new beats: last SHALL assert on the 10th new beat; no old data SHALL appear.
REQ-038 Random valid/ready toggling, P=4: scoreboard against the reference model; 1000 beats bit-exact.
